// File: rtl/fir_ctrl.sv
// -----------------------------------------------------------------------------
// fir_ctrl -- sequencer for the FIR datapath.
//
// Streams ile_probek input samples into the shift_R tap line, then scans every
// tap through adres while driving the MAC enables, and presents one result per
// convolution point. After the real samples the line is flushed with
// N_TAPS-1 zero samples, so one run yields ile_probek+N_TAPS-1 outputs.
//
// Optional feature (compile-time macro):
//   FIR_CTRL_ABORT_EN  adds the 1-bit 'abort' input; abort in any non-IDLE
//                      state returns to IDLE on the next cycle without a done
//                      pulse. Without the macro the port does not exist.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   abort        (FIR_CTRL_ABORT_EN only) cancel the current run
//   start        1-cycle pulse starting a run, ignored while busy
//   ile_probek   number of input samples, latched on an accepted start
//   in_valid     source holds a sample on in_data
//   in_ready     controller takes the sample (transfer = in_valid & in_ready)
//   in_data      input sample
//   probka_in    registered sample presented to shift_R
//   nowa_shift   1-cycle shift strobe to shift_R
//   reset_shift  1-cycle clear of shift_R at the start of a run
//   adres        tap address to shift_R / coefficient ROM
//   mac_en       MAC accumulate enable, aligned with adres
//   mac_clr      MAC clear-and-load, high together with adres = 0
//   mac_last     high together with adres = N_TAPS-1
//   out_valid    MAC result valid, held until out_ready
//   out_ready    sink accepts the result
//   out_idx      0-based index of the current output
//   busy         high from accepted start until done
//   done         1-cycle pulse when a run completes
//
// State table:
//   state     | meaning
//   IDLE      | waiting for start
//   CLEAR     | reset_shift pulse; empty run goes straight to DONE
//   WAIT_IN   | fetch a real sample (in_ready) or select a zero flush sample
//   SHIFT     | nowa_shift pulse, sample enters the tap line
//   MAC       | scan adres 0..N_TAPS-1 with mac_en
//   EMIT      | out_valid held until out_ready
//   DONE      | done pulse, back to IDLE
// -----------------------------------------------------------------------------
module fir_ctrl #(
  parameter int N_TAPS = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FIR_CTRL_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [CNT_W-1:0]  ile_probek,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] probka_in,
  output logic              nowa_shift,
  output logic              reset_shift,
  output logic [ADDR_W-1:0] adres,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              mac_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W:0]    out_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_SHIFT,
    S_MAC,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(N_TAPS - 1);
  localparam logic [CNT_W:0]    FLUSH_LEN = (CNT_W + 1)'(N_TAPS - 1);

  state_t state, state_nxt;

  // Latched sample count and the two progress counters. The output total is
  // formed one bit wider than ile_probek so the largest count cannot wrap.
  logic [CNT_W-1:0]  n_lat, n_lat_nxt;
  logic [CNT_W-1:0]  in_cnt, in_cnt_nxt;
  logic [CNT_W:0]    out_cnt_nxt;
  logic [CNT_W:0]    out_total;
  logic [CNT_W:0]    out_cnt_inc;
  logic [ADDR_W-1:0] adres_nxt;
  logic [DATA_W-1:0] probka_nxt;

  logic in_ready_nxt, nowa_shift_nxt, reset_shift_nxt;
  logic mac_en_nxt, mac_clr_nxt, mac_last_nxt;
  logic out_valid_nxt, busy_nxt, done_nxt;

  logic abort_req;
  logic in_xfer;
  logic out_xfer;

`ifdef FIR_CTRL_ABORT_EN
  assign abort_req = abort && (state != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign in_xfer     = (state == S_WAIT_IN) && in_ready && in_valid;
  assign out_xfer    = (state == S_EMIT) && out_valid && out_ready;
  assign out_total   = {1'b0, n_lat} + FLUSH_LEN;
  assign out_cnt_inc = out_idx + (CNT_W + 1)'(1);

  // ---------------------------------------------------------------------------
  // State and counter register. adres and out_idx are the tap and output
  // counters themselves, so they are registered outputs by construction.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      n_lat       <= '0;
      in_cnt      <= '0;
      out_idx     <= '0;
      adres       <= '0;
      probka_in   <= '0;
      in_ready    <= 1'b0;
      nowa_shift  <= 1'b0;
      reset_shift <= 1'b0;
      mac_en      <= 1'b0;
      mac_clr     <= 1'b0;
      mac_last    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      n_lat       <= n_lat_nxt;
      in_cnt      <= in_cnt_nxt;
      out_idx     <= out_cnt_nxt;
      adres       <= adres_nxt;
      probka_in   <= probka_nxt;
      in_ready    <= in_ready_nxt;
      nowa_shift  <= nowa_shift_nxt;
      reset_shift <= reset_shift_nxt;
      mac_en      <= mac_en_nxt;
      mac_clr     <= mac_clr_nxt;
      mac_last    <= mac_last_nxt;
      out_valid   <= out_valid_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and counter updates.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    n_lat_nxt   = n_lat;
    in_cnt_nxt  = in_cnt;
    out_cnt_nxt = out_idx;
    probka_nxt  = probka_in;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_CLEAR;
          n_lat_nxt   = ile_probek;
          in_cnt_nxt  = '0;
          out_cnt_nxt = '0;
        end
      end

      S_CLEAR: begin
        state_nxt = (n_lat == '0) ? S_DONE : S_WAIT_IN;
      end

      S_WAIT_IN: begin
        // in_ready already encodes in_cnt < n_lat for this visit; when it is
        // low the step is a flush and proceeds with a zero sample at once.
        if (in_ready) begin
          if (in_valid) begin
            state_nxt  = S_SHIFT;
            probka_nxt = in_data;
            in_cnt_nxt = in_cnt + CNT_W'(1);
          end
        end else begin
          state_nxt  = S_SHIFT;
          probka_nxt = '0;
        end
      end

      S_SHIFT: begin
        state_nxt = S_MAC;
      end

      S_MAC: begin
        if (adres == LAST_TAP) begin
          state_nxt = S_EMIT;
        end
      end

      S_EMIT: begin
        if (out_xfer) begin
          out_cnt_nxt = out_cnt_inc;
          state_nxt   = (out_cnt_inc == out_total) ? S_DONE : S_WAIT_IN;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort wins over any handshake in the same cycle: nothing is consumed
    // and no output is counted.
    if (abort_req) begin
      state_nxt   = S_IDLE;
      in_cnt_nxt  = in_cnt;
      out_cnt_nxt = out_idx;
      probka_nxt  = probka_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from the state being entered so that every
  // strobe lines up with the state it belongs to.
  // ---------------------------------------------------------------------------
  always_comb begin
    adres_nxt       = '0;
    in_ready_nxt    = 1'b0;
    nowa_shift_nxt  = 1'b0;
    reset_shift_nxt = 1'b0;
    mac_en_nxt      = 1'b0;
    mac_clr_nxt     = 1'b0;
    mac_last_nxt    = 1'b0;
    out_valid_nxt   = 1'b0;
    busy_nxt        = (state_nxt != S_IDLE);
    done_nxt        = 1'b0;

    case (state_nxt)
      S_CLEAR:   reset_shift_nxt = 1'b1;
      S_WAIT_IN: in_ready_nxt    = (in_cnt_nxt < n_lat_nxt);
      S_SHIFT:   nowa_shift_nxt  = 1'b1;
      S_MAC: begin
        // Scan starts at 0 on entry and steps once per cycle while in MAC.
        adres_nxt    = (state == S_MAC) ? adres + ADDR_W'(1) : '0;
        mac_en_nxt   = 1'b1;
        mac_clr_nxt  = (adres_nxt == '0);
        mac_last_nxt = (adres_nxt == LAST_TAP);
      end
      S_EMIT:    out_valid_nxt   = 1'b1;
      S_DONE:    done_nxt        = 1'b1;
      default: begin
      end
    endcase
  end

endmodule
